lamp_fpu_f2i: RTL and testbench

Sequential bfloat16-to-int32 converter for the lampFPU; it is the reverse of the I2F path and is selected by opcode `FPU_F2I`. It takes one 16-bit float operand, converts it over a fixed 3-cycle pipeline-style FSM, and returns a signed 32-bit integer with invalid and inexact flags. Rounding is either round-to-nearest-even or truncate, selected by `rndModeFPU_t`. The block sits beside the add/mul/div units under the FPU top and shares its start/flush/valid handshake.

---
 rtl/lampFPU_pkg.sv | 47 ++++
 rtl/lamp_fpu_f2i_round.sv | 24 ++
 rtl/lamp_fpu_f2i.sv | 148 ++++++++++++++
 tb/tb_lamp_fpu_f2i.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared lampFPU types and helpers used by the bfloat16-to-int32 conversion path.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_DW   = 16;
    localparam int LAMP_INTEGER_DW = 32;

    localparam logic [LAMP_INTEGER_DW-1:0] LAMP_INT_POS_SAT = 32'h7fffffff;
    localparam logic [LAMP_INTEGER_DW-1:0] LAMP_INT_NEG_SAT = 32'h80000000;

    typedef enum logic {
        FPU_RNDMODE_NEAREST  = 1'b0,
        FPU_RNDMODE_TRUNCATE = 1'b1
    } rndModeFPU_t;

    typedef enum logic [1:0] {F2I_IDLE, F2I_UNPACK, F2I_SHIFT, F2I_ROUND} f2iState_t;

    typedef enum logic [2:0] {
        F2I_CLS_ZERO,
        F2I_CLS_DENORM,
        F2I_CLS_NAN,
        F2I_CLS_INF,
        F2I_CLS_BIG,
        F2I_CLS_TINY,
        F2I_CLS_NORMAL
    } f2iClass_t;

    // BIG covers E >= 31 (biased 158) and TINY covers E < -1 (biased 126).
    function automatic f2iClass_t FUNC_f2iClassify(input logic [LAMP_FLOAT_DW-1:0] op);
        logic [7:0] e;
        logic [6:0] f;
        e = op[14:7];
        f = op[6:0];
        if (e == 8'd0) begin
            if (f == 7'd0) return F2I_CLS_ZERO;
            else           return F2I_CLS_DENORM;
        end else if (e == 8'hff) begin
            if (f != 7'd0) return F2I_CLS_NAN;
            else           return F2I_CLS_INF;
        end else if (e >= 8'd158) begin
            return F2I_CLS_BIG;
        end else if (e < 8'd126) begin
            return F2I_CLS_TINY;
        end
        return F2I_CLS_NORMAL;
    endfunction

endpackage

// File: rtl/lamp_fpu_f2i_round.sv
// Rounds an unsigned integer with guard/sticky bits and applies the sign.
module lamp_fpu_f2i_round
    import lampFPU_pkg::*;
(
    input  logic [LAMP_INTEGER_DW-1:0] int_i,
    input  logic                       guard_i,
    input  logic                       sticky_i,
    input  logic                       sign_i,
    input  rndModeFPU_t                rnd_mode_i,
    output logic [LAMP_INTEGER_DW-1:0] res_o,
    output logic                       inexact_o
);

    logic                       inc;
    logic [LAMP_INTEGER_DW-1:0] mag;

    always_comb begin
        inc       = (rnd_mode_i == FPU_RNDMODE_NEAREST) && guard_i && (sticky_i || int_i[0]);
        mag       = int_i + {{(LAMP_INTEGER_DW-1){1'b0}}, inc};
        res_o     = sign_i ? (~mag + 32'd1) : mag;
        inexact_o = guard_i | sticky_i;
    end

endmodule

// File: rtl/lamp_fpu_f2i.sv
// Sequential bfloat16 to int32 converter: IDLE -> UNPACK -> SHIFT -> ROUND, result valid in ROUND.
module lamp_fpu_f2i
    import lampFPU_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       doF2i_i,
    input  logic [LAMP_FLOAT_DW-1:0]   op_i,
    input  rndModeFPU_t                rndMode_i,
    output logic                       busy_o,
    output logic [LAMP_INTEGER_DW-1:0] res_o,
    output logic                       isValid_o,
    output logic                       invalid_o,
    output logic                       inexact_o
);

    f2iState_t                  state_q, state_d;
    logic [LAMP_FLOAT_DW-1:0]   op_q, op_d;
    rndModeFPU_t                rnd_q, rnd_d;
    logic                       s_q, s_d;
    logic signed [9:0]          exp_q, exp_d;
    logic [7:0]                 man_q, man_d;
    f2iClass_t                  cls_q, cls_d;
    logic [39:0]                v_q, v_d;
    logic [LAMP_INTEGER_DW-1:0] res_q, res_d;
    logic                       invalid_q, invalid_d;
    logic                       inexact_q, inexact_d;

    logic [9:0]                 sh_sum;
    logic [LAMP_INTEGER_DW-1:0] rnd_res, fin_res;
    logic                       rnd_inexact, fin_invalid, fin_inexact;

    lamp_fpu_f2i_round u_round (
        .int_i      (v_q[39:8]),
        .guard_i    (v_q[7]),
        .sticky_i   (|v_q[6:0]),
        .sign_i     (s_q),
        .rnd_mode_i (rnd_q),
        .res_o      (rnd_res),
        .inexact_o  (rnd_inexact)
    );

    // Special classes override the rounded datapath; -2^31 is the one exact BIG value.
    always_comb begin
        fin_res     = '0;
        fin_invalid = 1'b0;
        fin_inexact = 1'b0;
        case (cls_q)
            F2I_CLS_ZERO: ;
            F2I_CLS_DENORM,
            F2I_CLS_TINY: fin_inexact = 1'b1;
            F2I_CLS_NAN: begin
                fin_res     = LAMP_INT_POS_SAT;
                fin_invalid = 1'b1;
            end
            F2I_CLS_INF,
            F2I_CLS_BIG: begin
                if (cls_q == F2I_CLS_BIG && s_q && exp_q == 10'sd31 && man_q[6:0] == 7'd0) begin
                    fin_res = LAMP_INT_NEG_SAT;
                end else begin
                    fin_res     = s_q ? LAMP_INT_NEG_SAT : LAMP_INT_POS_SAT;
                    fin_invalid = 1'b1;
                end
            end
            default: begin
                fin_res     = rnd_res;
                fin_inexact = rnd_inexact;
            end
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rnd_d     = rnd_q;
        s_d       = s_q;
        exp_d     = exp_q;
        man_d     = man_q;
        cls_d     = cls_q;
        v_d       = v_q;
        sh_sum    = exp_q + 10'sd1;

        busy_o    = (state_q != F2I_IDLE);
        isValid_o = (state_q == F2I_ROUND) && !flush_i;
        res_o     = isValid_o ? fin_res     : res_q;
        invalid_o = isValid_o ? fin_invalid : invalid_q;
        inexact_o = isValid_o ? fin_inexact : inexact_q;
        res_d     = res_o;
        invalid_d = invalid_o;
        inexact_d = inexact_o;

        case (state_q)
            F2I_IDLE: begin
                if (doF2i_i) begin
                    op_d    = op_i;
                    rnd_d   = rndMode_i;
                    state_d = F2I_UNPACK;
                end
            end
            F2I_UNPACK: begin
                s_d     = op_q[15];
                exp_d   = $signed({2'b00, op_q[14:7]}) - 10'sd127;
                man_d   = {|op_q[14:7], op_q[6:0]};
                cls_d   = FUNC_f2iClassify(op_q);
                state_d = F2I_SHIFT;
            end
            F2I_SHIFT: begin
                v_d     = (cls_q == F2I_CLS_NORMAL) ? ({32'd0, man_q} << sh_sum[4:0]) : 40'd0;
                state_d = F2I_ROUND;
            end
            default: state_d = F2I_IDLE;
        endcase

        if (flush_i) state_d = F2I_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments and every register, datapath included, is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= F2I_IDLE;
            op_q      <= '0;
            rnd_q     <= FPU_RNDMODE_NEAREST;
            s_q       <= 1'b0;
            exp_q     <= '0;
            man_q     <= '0;
            cls_q     <= F2I_CLS_ZERO;
            v_q       <= '0;
            res_q     <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rnd_q     <= rnd_d;
            s_q       <= s_d;
            exp_q     <= exp_d;
            man_q     <= man_d;
            cls_q     <= cls_d;
            v_q       <= v_d;
            res_q     <= res_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

endmodule

// File: tb/tb_lamp_fpu_f2i.sv
// Directed bench for lamp_fpu_f2i: conversions, range edges, specials, handshake, flush and reset.
module tb_lamp_fpu_f2i;
    import lampFPU_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        doF2i_i = 1'b0;
    logic [15:0] op_i = 16'h0;
    rndModeFPU_t rndMode_i = FPU_RNDMODE_NEAREST;
    logic        busy_o;
    logic [31:0] res_o;
    logic        isValid_o;
    logic        invalid_o;
    logic        inexact_o;

    int checks = 0;
    int failures = 0;

    localparam rndModeFPU_t RN = FPU_RNDMODE_NEAREST;
    localparam rndModeFPU_t RZ = FPU_RNDMODE_TRUNCATE;

    lamp_fpu_f2i dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .doF2i_i   (doF2i_i),
        .op_i      (op_i),
        .rndMode_i (rndMode_i),
        .busy_o    (busy_o),
        .res_o     (res_o),
        .isValid_o (isValid_o),
        .invalid_o (invalid_o),
        .inexact_o (inexact_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the accepting edge (start of cycle N+1).
    task automatic strobe(input logic [15:0] op, input rndModeFPU_t rnd);
        @(posedge clk);
        #1;
        doF2i_i   = 1'b1;
        op_i      = op;
        rndMode_i = rnd;
        @(posedge clk);
        #1;
        doF2i_i = 1'b0;
    endtask

    task automatic observe(input int ncyc, output int lat, output int pulses,
                           output logic [31:0] r, output logic inv, output logic inx);
        lat = 0; pulses = 0; r = '0; inv = 1'b0; inx = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (isValid_o) begin
                pulses++;
                if (lat == 0) begin
                    lat = k; r = res_o; inv = invalid_o; inx = inexact_o;
                end
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] op, input rndModeFPU_t rnd,
                       input logic [31:0] exp_res, input logic exp_inv, input logic exp_inx);
        int lat, pulses;
        logic [31:0] r;
        logic inv, inx;
        strobe(op, rnd);
        observe(6, lat, pulses, r, inv, inx);
        check({tag, ".lat"}, lat, 3);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".res"}, r, exp_res);
        check({tag, ".invalid"}, inv, exp_inv);
        check({tag, ".inexact"}, inx, exp_inx);
    endtask

    initial begin
        int lat, pulses, first_k, second_k;
        logic [31:0] r, first_r, second_r;
        logic inv, inx;

        #1;
        check("rst.res", res_o, 32'h0);
        check("rst.valid", isValid_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.flags", {invalid_o, inexact_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle latency and busy window for 1.5.
        strobe(16'h3FC0, RN);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("lat.busy%0d", k), busy_o, (k <= 3) ? 1 : 0);
            check($sformatf("lat.valid%0d", k), isValid_o, (k == 3) ? 1 : 0);
            if (k == 3) check("lat.res", res_o, 32'd2);
        end

        run("p1_5_rn",   16'h3FC0, RN, 32'd2,          0, 1);
        run("p1_5_rz",   16'h3FC0, RZ, 32'd1,          0, 1);
        run("n1_5_rn",   16'hBFC0, RN, 32'hFFFFFFFE,   0, 1);
        run("p2_5_rn",   16'h4020, RN, 32'd2,          0, 1);
        run("n2_5_rn",   16'hC020, RN, 32'hFFFFFFFE,   0, 1);
        run("p123_5_rn", 16'h42F7, RN, 32'd124,        0, 1);
        run("p123_5_rz", 16'h42F7, RZ, 32'd123,        0, 1);
        run("p0_5_rn",   16'h3F00, RN, 32'd0,          0, 1);
        run("p2e31",     16'h4F00, RN, 32'h7FFFFFFF,   1, 0);
        run("n2e31",     16'hCF00, RN, 32'h80000000,   0, 0);
        run("maxnorm",   16'h4EFF, RN, 32'h7F800000,   0, 0);
        run("nan",       16'h7FC0, RN, 32'h7FFFFFFF,   1, 0);
        run("ninf",      16'hFF80, RN, 32'h80000000,   1, 0);
        run("denorm",    16'h0001, RN, 32'd0,          0, 1);
        run("nzero",     16'h8000, RN, 32'd0,          0, 0);
        run("tiny_rn",   16'h3E80, RN, 32'd0,          0, 1);
        run("tiny_rz",   16'h3E80, RZ, 32'd0,          0, 1);

        // Strobe held through the busy window, then a new operand accepted at N+4.
        @(posedge clk);
        #1;
        doF2i_i = 1'b1; op_i = 16'h42F7; rndMode_i = RN;
        @(posedge clk);
        #1;
        op_i = 16'h3FC0; rndMode_i = RZ;
        pulses = 0; first_k = 0; second_k = 0; first_r = '0; second_r = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 4) check("b2b.busy_gap", busy_o, 0);
            if (isValid_o) begin
                pulses++;
                if (first_k == 0) begin first_k = k; first_r = res_o; end
                else if (second_k == 0) begin second_k = k; second_r = res_o; end
            end
            if (k == 3) begin op_i = 16'hC020; rndMode_i = RN; end
            if (k == 5) doF2i_i = 1'b0;
        end
        check("b2b.pulses", pulses, 2);
        check("b2b.first_k", first_k, 3);
        check("b2b.first_res", first_r, 32'd124);
        check("b2b.second_k", second_k, 7);
        check("b2b.second_res", second_r, 32'hFFFFFFFE);

        // Flush during SHIFT: no pulse, result held.
        strobe(16'h4020, RN);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush.busy_shift", busy_o, 1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush.busy_after", busy_o, 0);
        check("flush.valid_after", isValid_o, 0);
        check("flush.res_held", res_o, 32'hFFFFFFFE);
        observe(5, lat, pulses, r, inv, inx);
        check("flush.pulses", pulses, 0);

        // Flush wins over a strobe in IDLE.
        @(posedge clk);
        #1;
        doF2i_i = 1'b1; flush_i = 1'b1; op_i = 16'h3FC0;
        @(posedge clk);
        #1;
        doF2i_i = 1'b0; flush_i = 1'b0;
        observe(5, lat, pulses, r, inv, inx);
        check("flush_idle.pulses", pulses, 0);
        check("flush_idle.busy", busy_o, 0);

        // Asynchronous reset during ROUND.
        run("pre_rst", 16'h42F7, RN, 32'd124, 0, 1);
        strobe(16'h4EFF, RN);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_round.valid_before", isValid_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_round.res", res_o, 32'h0);
        check("rst_round.valid", isValid_o, 0);
        check("rst_round.busy", busy_o, 0);
        check("rst_round.flags", {invalid_o, inexact_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observe(6, lat, pulses, r, inv, inx);
        check("rst_round.pulses", pulses, 0);
        check("rst_round.res_after", res_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
